// File: rtl/switch_allocator_if.sv
// Allocator-facing router bus: head-flit requests and downstream credits in,
// per-input crossbar grants and per-output lock status out.
interface switch_allocator_if #(
  parameter int IN_PORTS      = 5,
  parameter int OUT_PORTS     = 5,
  parameter int OUT_PORT_BITS = 3
);
  logic [IN_PORTS-1:0]               requests;
  logic [IN_PORTS*OUT_PORT_BITS-1:0] req_ports;
  logic [IN_PORTS-1:0]               tail;
  logic [OUT_PORTS-1:0]              out_ready;
  logic [IN_PORTS-1:0]               grants;
  logic [OUT_PORTS-1:0]              out_locked;

  modport master (output requests, req_ports, tail, out_ready, input grants, out_locked);
  modport slave  (input requests, req_ports, tail, out_ready, output grants, out_locked);
endinterface

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: one round-robin arbiter per output port, each holding
// its output for a single input from head flit to tail flit.
module switch_allocator_out #(
  parameter int IN_PORTS     = 5,
  parameter int IN_PORT_BITS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IN_PORTS-1:0]     req,
  input  logic [IN_PORTS-1:0]     busy,
  input  logic [IN_PORTS-1:0]     tail,
  input  logic                    ready,
  output logic [IN_PORTS-1:0]     gnt,
  output logic                    locked,
  output logic [IN_PORT_BITS-1:0] owner
);
  localparam logic [IN_PORT_BITS-1:0] LAST = IN_PORT_BITS'(IN_PORTS-1);

  logic [IN_PORT_BITS-1:0] rr_ptr, win, cand;
  logic                    found;

  // Locked: only the owner may go, and only if it still names this output.
  // Unlocked: first non-busy requester scanning cyclically from rr_ptr.
  always_comb begin
    win   = owner;
    found = 1'b0;
    cand  = rr_ptr;
    if (locked) begin
      found = req[owner];
    end else begin
      for (int k = 0; k < IN_PORTS; k++) begin
        if (!found && req[cand] && !busy[cand]) begin
          win   = cand;
          found = 1'b1;
        end
        cand = (cand == LAST) ? '0 : cand + 1'b1;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (found && ready && !reset) gnt[win] = 1'b1;
  end

  // Pointer moves only on tail so a packet never rotates priority mid-flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked <= 1'b0;
      owner  <= '0;
      rr_ptr <= '0;
    end else if (|gnt) begin
      if (tail[win]) begin
        locked <= 1'b0;
        rr_ptr <= (win == LAST) ? '0 : win + 1'b1;
      end else begin
        locked <= 1'b1;
        owner  <= win;
      end
    end
  end
endmodule

module switch_allocator #(
  parameter int IN_PORTS      = 5,
  parameter int OUT_PORTS     = 5,
  parameter int OUT_PORT_BITS = 3,
  parameter int IN_PORT_BITS  = 3
) (
  input  logic              clk,
  input  logic              reset,
  switch_allocator_if.slave bus
);
  logic [OUT_PORTS-1:0][IN_PORTS-1:0]     req_mask, gnt_mask;
  logic [OUT_PORTS-1:0][IN_PORT_BITS-1:0] owner;
  logic [OUT_PORTS-1:0]                   locked;
  logic [IN_PORTS-1:0]                    busy, grants;

  // Out-of-range port indices match no output, so invalid requests drop out here.
  always_comb begin
    req_mask = '0;
    for (int o = 0; o < OUT_PORTS; o++)
      for (int i = 0; i < IN_PORTS; i++)
        req_mask[o][i] = bus.requests[i] &&
          (bus.req_ports[i*OUT_PORT_BITS +: OUT_PORT_BITS] == OUT_PORT_BITS'(o));
  end

  always_comb begin
    busy = '0;
    for (int o = 0; o < OUT_PORTS; o++)
      if (locked[o]) busy[owner[o]] = 1'b1;
  end

  for (genvar o = 0; o < OUT_PORTS; o++) begin : g_out
    switch_allocator_out #(
      .IN_PORTS    (IN_PORTS),
      .IN_PORT_BITS(IN_PORT_BITS)
    ) u_out (
      .clk   (clk),
      .reset (reset),
      .req   (req_mask[o]),
      .busy  (busy),
      .tail  (bus.tail),
      .ready (bus.out_ready[o]),
      .gnt   (gnt_mask[o]),
      .locked(locked[o]),
      .owner (owner[o])
    );
  end

  always_comb begin
    grants = '0;
    for (int o = 0; o < OUT_PORTS; o++) grants = grants | gnt_mask[o];
  end

  assign bus.grants     = grants;
  assign bus.out_locked = locked;
endmodule

// File: tb/tb_switch_allocator.sv
// Directed scenarios plus randomized traffic checked against a packet-level model.
module tb_switch_allocator;
  logic       clk;
  logic       reset;
  logic [4:0] req, tl, rdy;
  logic [2:0] ports [5];
  int         vectors, miscompares;
  int         m_locked [5];
  int         m_owner  [5];
  int         m_ptr    [5];

  switch_allocator_if #(.IN_PORTS(5), .OUT_PORTS(5), .OUT_PORT_BITS(3)) bus ();

  switch_allocator #(
    .IN_PORTS(5), .OUT_PORTS(5), .OUT_PORT_BITS(3), .IN_PORT_BITS(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply();
    bus.requests  = req;
    bus.tail      = tl;
    bus.out_ready = rdy;
    for (int i = 0; i < 5; i++) bus.req_ports[i*3 +: 3] = ports[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0; tl = '0; rdy = '1;
    for (int i = 0; i < 5; i++) ports[i] = '0;
    apply();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int o = 0; o < 5; o++) begin
      m_locked[o] = 0; m_owner[o] = 0; m_ptr[o] = 0;
    end
  endtask

  // Reference model: grant decision from the allocation rules on plain integers.
  function automatic logic [4:0] model_grants();
    logic [4:0] g;
    g = '0;
    for (int o = 0; o < 5; o++) begin
      if (m_locked[o] != 0) begin
        int i;
        i = m_owner[o];
        if (req[i] && int'(ports[i]) == o && rdy[o]) g[i] = 1'b1;
      end else if (rdy[o]) begin
        bit done;
        done = 1'b0;
        for (int k = 0; k < 5; k++) begin
          int i;
          bit busy;
          i = (m_ptr[o] + k) % 5;
          busy = 1'b0;
          for (int p = 0; p < 5; p++)
            if (m_locked[p] != 0 && m_owner[p] == i) busy = 1'b1;
          if (!done && req[i] && int'(ports[i]) == o && !busy) begin
            g[i] = 1'b1;
            done = 1'b1;
          end
        end
      end
    end
    return g;
  endfunction

  function automatic logic [4:0] model_locked();
    logic [4:0] l;
    for (int o = 0; o < 5; o++) l[o] = (m_locked[o] != 0);
    return l;
  endfunction

  task automatic model_update(input logic [4:0] g);
    for (int i = 0; i < 5; i++) begin
      if (g[i]) begin
        int o;
        o = int'(ports[i]);
        if (tl[i]) begin
          m_locked[o] = 0;
          m_ptr[o]    = (i + 1) % 5;
        end else begin
          m_locked[o] = 1;
          m_owner[o]  = i;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 5'b11111; tl = '0; rdy = '1;
    for (int i = 0; i < 5; i++) ports[i] = 3'(i);
    apply();
    #1;
    vectors++;
    if (bus.grants !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_grants: got %b want %b", bus.grants, 5'b00000);
    end
    vectors++;
    if (bus.out_locked !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_locked: got %b want %b", bus.out_locked, 5'b00000);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.grants !== 5'b11111) begin
      miscompares++;
      $display("FAIL post_reset_grants: got %b want %b", bus.grants, 5'b11111);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (bus.out_locked !== 5'b11111) begin
      miscompares++;
      $display("FAIL post_reset_locked: got %b want %b", bus.out_locked, 5'b11111);
    end
  endtask

  task automatic test_single_flit();
    logic [4:0] t_req [3] = '{5'b00001, 5'b00011, 5'b00011};
    logic [4:0] t_g   [3] = '{5'b00001, 5'b00010, 5'b00001};
    do_reset();
    ports[0] = 3'd2; ports[1] = 3'd2;
    for (int c = 0; c < 3; c++) begin
      req = t_req[c]; tl = 5'b11111; rdy = '1;
      apply();
      #1;
      vectors++;
      if (bus.grants !== t_g[c]) begin
        miscompares++;
        $display("FAIL single_grant c%0d: got %b want %b", c, bus.grants, t_g[c]);
      end
      vectors++;
      if (bus.out_locked !== 5'b00000) begin
        miscompares++;
        $display("FAIL single_locked c%0d: got %b want %b", c, bus.out_locked, 5'b00000);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] t_g [6] = '{5'b00001, 5'b00010, 5'b01000, 5'b00001, 5'b00010, 5'b01000};
    do_reset();
    for (int i = 0; i < 5; i++) ports[i] = 3'd4;
    req = 5'b01011; tl = 5'b11111; rdy = '1;
    apply();
    for (int c = 0; c < 6; c++) begin
      #1;
      vectors++;
      if (bus.grants !== t_g[c]) begin
        miscompares++;
        $display("FAIL rr_grant c%0d: got %b want %b", c, bus.grants, t_g[c]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wormhole();
    logic [4:0] t_req [5] = '{5'b00001, 5'b00101, 5'b00101, 5'b00101, 5'b00001};
    logic [4:0] t_tl  [5] = '{5'b00001, 5'b00001, 5'b00001, 5'b00101, 5'b00001};
    logic [4:0] t_g   [5] = '{5'b00001, 5'b00100, 5'b00100, 5'b00100, 5'b00001};
    logic [4:0] t_lk  [5] = '{5'b00000, 5'b00000, 5'b00010, 5'b00010, 5'b00000};
    do_reset();
    ports[0] = 3'd1; ports[2] = 3'd1;
    for (int c = 0; c < 5; c++) begin
      req = t_req[c]; tl = t_tl[c]; rdy = '1;
      apply();
      #1;
      vectors++;
      if (bus.grants !== t_g[c]) begin
        miscompares++;
        $display("FAIL worm_grant c%0d: got %b want %b", c, bus.grants, t_g[c]);
      end
      vectors++;
      if (bus.out_locked !== t_lk[c]) begin
        miscompares++;
        $display("FAIL worm_locked c%0d: got %b want %b", c, bus.out_locked, t_lk[c]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] t_req [6] = '{5'b01100, 5'b01100, 5'b01100, 5'b01100, 5'b01100, 5'b01000};
    logic [4:0] t_tl  [6] = '{5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b01100, 5'b01000};
    logic [4:0] t_rdy [6] = '{5'b11111, 5'b11101, 5'b11101, 5'b11111, 5'b11111, 5'b11111};
    logic [4:0] t_g   [6] = '{5'b01100, 5'b01000, 5'b01000, 5'b01100, 5'b01100, 5'b01000};
    logic [4:0] t_lk  [6] = '{5'b00000, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00000};
    do_reset();
    ports[2] = 3'd1; ports[3] = 3'd0;
    for (int c = 0; c < 6; c++) begin
      req = t_req[c]; tl = t_tl[c]; rdy = t_rdy[c];
      apply();
      #1;
      vectors++;
      if (bus.grants !== t_g[c]) begin
        miscompares++;
        $display("FAIL bp_grant c%0d: got %b want %b", c, bus.grants, t_g[c]);
      end
      vectors++;
      if (bus.out_locked !== t_lk[c]) begin
        miscompares++;
        $display("FAIL bp_locked c%0d: got %b want %b", c, bus.out_locked, t_lk[c]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_invalid_port();
    do_reset();
    ports[0] = 3'd3;
    for (int c = 0; c < 4; c++) begin
      ports[4] = (c < 2) ? 3'd6 : 3'd5;
      req = 5'b10001; tl = 5'b00001; rdy = '1;
      apply();
      #1;
      vectors++;
      if (bus.grants !== 5'b00001) begin
        miscompares++;
        $display("FAIL invalid_grant c%0d: got %b want %b", c, bus.grants, 5'b00001);
      end
      vectors++;
      if (bus.out_locked !== 5'b00000) begin
        miscompares++;
        $display("FAIL invalid_locked c%0d: got %b want %b", c, bus.out_locked, 5'b00000);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    ports[0] = 3'd1; ports[2] = 3'd1;
    req = 5'b00001; tl = 5'b00001; rdy = '1;
    apply();
    @(negedge clk);
    req = 5'b00100; tl = 5'b00000;
    apply();
    @(negedge clk);
    #1;
    vectors++;
    if (bus.out_locked !== 5'b00010) begin
      miscompares++;
      $display("FAIL midrst_pre_locked: got %b want %b", bus.out_locked, 5'b00010);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.out_locked !== 5'b00000) begin
      miscompares++;
      $display("FAIL midrst_locked: got %b want %b", bus.out_locked, 5'b00000);
    end
    vectors++;
    if (bus.grants !== 5'b00000) begin
      miscompares++;
      $display("FAIL midrst_grants: got %b want %b", bus.grants, 5'b00000);
    end
    @(negedge clk);
    reset = 1'b0;
    req = 5'b00101; tl = 5'b00101;
    apply();
    #1;
    vectors++;
    if (bus.grants !== 5'b00001) begin
      miscompares++;
      $display("FAIL midrst_restart: got %b want %b", bus.grants, 5'b00001);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [4:0] exp_g, exp_l;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 4) == 0) ports[i] = 3'($urandom_range(0, 6));
        req[i] = ($urandom_range(0, 9) < 7);
        tl[i]  = ($urandom_range(0, 9) < 4);
        rdy[i] = ($urandom_range(0, 19) < 17);
      end
      apply();
      #1;
      exp_g = model_grants();
      exp_l = model_locked();
      vectors++;
      if (bus.grants !== exp_g) begin
        miscompares++;
        $display("FAIL rand_grant c%0d: got %b want %b", c, bus.grants, exp_g);
      end
      vectors++;
      if (bus.out_locked !== exp_l) begin
        miscompares++;
        $display("FAIL rand_locked c%0d: got %b want %b", c, bus.out_locked, exp_l);
      end
      model_update(exp_g);
      @(negedge clk);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_flit();
    test_round_robin();
    test_wormhole();
    test_backpressure();
    test_invalid_port();
    test_reset_mid_packet();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/switch_allocator.md
# switch_allocator

Per-output wormhole switch allocator for the router datapath, placed directly upstream of the crossbar. Each cycle it takes the head-flit requests from the input buffers and produces the per-input `grants` vector. The crossbar and the input buffers both sample that vector on the same clock edge. The allocator arbitrates each output port round-robin, locks an output to one input from head flit to tail flit, and never grants into an output that reports no downstream space.

## Interface
- `IN_PORTS`, 5, number of router input ports.
- `OUT_PORTS`, 5, number of router output ports.
- `OUT_PORT_BITS`, 3, width of one output-port index.
- `IN_PORT_BITS`, 3, width of one input-port index (owner and pointer registers).
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `requests`  in  IN_PORTS  bit i: input i has a flit at its buffer head.
- `req_ports`  in  IN_PORTS*OUT_PORT_BITS  slice i = [(i+1)*OUT_PORT_BITS-1 -: OUT_PORT_BITS], output requested by input i.
- `tail`  in  IN_PORTS  bit i: head flit of input i is the last flit of its packet.
- `out_ready`  in  OUT_PORTS  bit o: downstream of output o can accept a flit this cycle.
- `grants`  out  IN_PORTS  combinational; bit i: input i's head flit traverses the crossbar at this edge. Same encoding as the crossbar's `grants`.
- `out_locked`  out  OUT_PORTS  registered; bit o: output o is held by an in-progress packet.

## Operation
- A request from input i is valid only when `requests[i]` is 1 and `req_ports[i] < OUT_PORTS`. Invalid requests are ignored and never granted.
- Per output o, registered state:
  - `locked[o]`, 1 bit.
  - `owner[o]`, IN_PORT_BITS bits.
  - `rr_ptr[o]`, IN_PORT_BITS bits, range 0..IN_PORTS-1.
- An input is busy if it is `owner[o]` of some locked output o.
- Output o, locked:
  - Grant `owner[o]` iff its request is valid, `req_ports[owner] == o`, and `out_ready[o]` is 1.
  - Every other request for o is denied.
- Output o, unlocked:
  - Candidates are inputs with a valid request for o that are not busy.
  - Winner is the first candidate found scanning cyclically from `rr_ptr[o]`.
  - The winner is granted iff `out_ready[o]` is 1. With no candidate, or `out_ready[o]` low, nothing is granted and no state changes.
- Each input names exactly one output, so at most one grant per input and one per output per cycle.
- State update on a grant of input i into output o:
  - `tail[i]` is 0: set `locked[o]`=1 and `owner[o]`=i. Writing the same values again while already locked is harmless.
  - `tail[i]` is 1: set `locked[o]`=0 and `rr_ptr[o]`=(i+1) mod IN_PORTS. This includes single-flit packets granted while unlocked.
- `rr_ptr[o]` advances only at packet completion, so a multi-flit packet does not rotate priority mid-packet.
- Protocol violation: the owner requests a different output while it holds a lock. The result is no grant on either output, and the lock is kept.
- `out_locked` = `locked`.
- `grants` is forced to all-zero while `reset` is high.

## Timing
- `grants` has zero latency: it is a combinational function of the inputs and current state, valid within the same cycle. The crossbar and input buffers consume it at the next rising edge.
- State changes take effect in the cycle after the granting edge.
- Back-to-back flits from the owner are granted every cycle while `out_ready` stays 1.
- Tail grant at edge N: a different input can win output o in cycle N+1, with no bubble.
- `out_ready[o]` low stalls output o only. The lock, owner and pointer are held, and other outputs proceed.
- Reset, including assertion mid-packet:
  - `locked`, `owner`, `rr_ptr` go to 0 and `out_locked` goes to 0 asynchronously.
  - `grants` is 0 while `reset` is high.
  - After deassertion, arbitration restarts from `rr_ptr`=0. The partial packet is abandoned, and recovery is the buffers' responsibility.
- Requests for the same output that arrive together in the first cycle after reset: lowest index at or above 0 wins.

## Test plan
- Single flit: `requests`=00001, input0→port 2, `tail`=1, `out_ready`=all 1 → `grants`=00001 that cycle. `out_locked` stays 0. `rr_ptr[2]` becomes 1.
- Round robin: inputs 0, 1 and 3 all request port 4 with single-flit packets every cycle → grant order 0, 1, 3, 0, 1, 3, one per cycle.
- Wormhole lock:
  - Input 2 sends a 3-flit packet to port 1, with `tail` on flit 3. Input 0 also requests port 1.
  - Input 2 is granted 3 consecutive cycles while `out_locked[1]`=1.
  - Input 0 is granted in cycle 4, and `out_locked[1]` returns to 0.
- Backpressure: mid-packet, `out_ready[1]`=0 for 2 cycles → no grants to port 1, lock is held. After release, the owner resumes and input 3's concurrent request to port 0 is granted throughout.
- Invalid port: input 4 requests port 6 → never granted, and no state change.
- Reset mid-packet: assert `reset` asynchronously between edges while `out_locked[1]`=1 → `out_locked`=0 and `grants`=0 immediately. After release, input 0 wins port 1 over input 2 (pointer back at 0).
